// File: rtl/jt93cxx.sv
// Microwire 93C46/56/66/86 serial EEPROM emulator, x8 or x16 organisation.
// Define JT93CXX_HOST_EN to add a host port for NVRAM load/save.
module jt93cxx #(
  parameter int unsigned AW  = 6,
  parameter int unsigned DW  = 16,
  parameter int unsigned TWP = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic sdi,
  input  logic scs,
  output logic sdo,
  output logic host_busy
`ifdef JT93CXX_HOST_EN
  ,
  input  logic [AW+(DW==8?1:0)-1:0] host_addr,
  input  logic [DW-1:0]             host_din,
  input  logic                      host_we,
  output logic [DW-1:0]             host_dout
`endif
);

  localparam int unsigned A     = (DW == 8) ? AW + 1 : AW;
  localparam int unsigned RXB   = A + 2;
  localparam int unsigned CW    = $clog2(((RXB > DW) ? RXB : DW) + 1);
  localparam int unsigned TW    = (TWP > 1) ? $clog2(TWP) : 1;
  localparam int unsigned TWPM1 = (TWP > 0) ? TWP - 1 : 0;
  localparam int unsigned DEPTH = 2 ** A;

  typedef enum logic [2:0] {StIdle, StRx, StWdata, StRead, StFill, StBusy} st_t;

  // With no busy time, programming returns straight to idle.
  localparam st_t StDone = (TWP == 0) ? StIdle : StBusy;

  st_t            st_q, st_d;
  logic           sclk_q;
  logic           wr_en_q, wr_en_d;
  logic           all_q, all_d;
  logic           sdo_q, sdo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  bcnt_q, bcnt_d;
  logic [RXB-2:0] rx_q, rx_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [DW-1:0]  sh_q, sh_d;

  logic           mem_we;
  logic [A-1:0]   mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem [DEPTH] = '{default: '1};

  logic           sedge;
  logic [RXB-1:0] rx_full;
  logic [DW-1:0]  wd_full;
  logic [A-1:0]   rx_addr;
  logic [1:0]     rx_op;
  logic [1:0]     rx_sub;

  assign sedge   = sclk & ~sclk_q;
  assign rx_full = {rx_q, sdi};
  assign wd_full = {sh_q[DW-2:0], sdi};
  assign rx_addr = rx_full[A-1:0];
  assign rx_op   = rx_full[RXB-1:RXB-2];
  assign rx_sub  = rx_full[A-1:A-2];

  always_comb begin
    st_d      = st_q;
    wr_en_d   = wr_en_q;
    all_d     = all_q;
    sdo_d     = sdo_q;
    cnt_d     = cnt_q;
    bcnt_d    = '0;
    rx_d      = rx_q;
    addr_d    = addr_q;
    sh_d      = sh_q;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = sh_q;
    unique case (st_q)
      StIdle: begin
        cnt_d = '0;
        if (sedge && scs && sdi) st_d = StRx;
      end
      StRx: begin
        if (!scs) begin
          st_d = StIdle;
        end else if (sedge) begin
          rx_d  = rx_full[RXB-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(RXB - 1)) begin
            st_d   = StIdle;
            cnt_d  = '0;
            addr_d = rx_addr;
            all_d  = 1'b0;
            unique case (rx_op)
              2'b10: begin
                sh_d  = mem[rx_addr];
                sdo_d = 1'b0;
                st_d  = StRead;
              end
              2'b01: if (wr_en_q) st_d = StWdata;
              2'b11: begin
                if (wr_en_q) begin
                  mem_we    = 1'b1;
                  mem_addr  = rx_addr;
                  mem_wdata = '1;
                  st_d      = StDone;
                end
              end
              default: begin
                unique case (rx_sub)
                  2'b11: wr_en_d = 1'b1;
                  2'b00: wr_en_d = 1'b0;
                  2'b10: begin
                    if (wr_en_q) begin
                      sh_d   = '1;
                      addr_d = '0;
                      st_d   = StFill;
                    end
                  end
                  default: begin
                    if (wr_en_q) begin
                      all_d = 1'b1;
                      st_d  = StWdata;
                    end
                  end
                endcase
              end
            endcase
          end
        end
      end
      StWdata: begin
        if (!scs) begin
          st_d = StIdle;
        end else if (sedge) begin
          sh_d  = wd_full;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d = '0;
            if (all_q) begin
              addr_d = '0;
              st_d   = StFill;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = wd_full;
              st_d      = StDone;
            end
          end
        end
      end
      StRead: begin
        if (!scs) begin
          st_d = StIdle;
        end else if (sedge) begin
          sdo_d = sh_q[DW-1];
          sh_d  = {sh_q[DW-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          // Last bit of the word goes out while the next word loads: no gap.
          if (cnt_q == CW'(DW - 1)) begin
            cnt_d  = '0;
            addr_d = addr_q + 1'b1;
            sh_d   = mem[addr_d];
          end
        end
      end
      StFill: begin
        mem_we = 1'b1;
        addr_d = addr_q + 1'b1;
        if (&addr_q) st_d = StDone;
      end
      StBusy: begin
        if (bcnt_q == TW'(TWPM1)) st_d = StIdle;
        else bcnt_d = bcnt_q + 1'b1;
      end
      default: st_d = StIdle;
    endcase
    if (st_d != StRead) sdo_d = !((st_d == StFill) || (st_d == StBusy));
`ifdef JT93CXX_HOST_EN
    if ((st_q == StIdle) && host_we) begin
      mem_we    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_din;
    end
`endif
  end

  always_ff @(posedge clk) begin
    sclk_q <= sclk;
    if (!rst_n) begin
      st_q    <= StIdle;
      wr_en_q <= 1'b0;
      all_q   <= 1'b0;
      sdo_q   <= 1'b1;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      rx_q    <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
    end else begin
      st_q    <= st_d;
      wr_en_q <= wr_en_d;
      all_q   <= all_d;
      sdo_q   <= sdo_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
    end
  end

  // Array contents survive reset; only an in-reset cycle blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[mem_addr] <= mem_wdata;
  end

`ifdef JT93CXX_HOST_EN
  always_ff @(posedge clk) begin
    host_dout <= mem[host_addr];
  end
`endif

  assign sdo       = sdo_q;
  assign host_busy = (st_q == StFill) || (st_q == StBusy);

endmodule

// File: tb/tb_jt93cxx.sv
// Self-checking bench for jt93cxx: x16 (AW=6) and x8 (AW=6, DW=8) instances against an array model.
module tb_jt93cxx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic scs = 1'b0;
  logic sel = 1'b0;
  logic sdo16, hb16, sdo8, hb8;

  int checks = 0;
  int errs = 0;
  int na = 6;
  int nd = 16;
  logic [15:0] ref16 [64];
  logic [7:0]  ref8  [128];
  logic        we16, we8;

`ifdef JT93CXX_HOST_EN
  logic [5:0]  ha16 = '0;
  logic [15:0] hd16 = '0;
  logic        hw16 = 1'b0;
  logic [15:0] hq16;
  logic [6:0]  ha8 = '0;
  logic [7:0]  hd8 = '0;
  logic        hw8 = 1'b0;
  logic [7:0]  hq8;
`endif

  always #5 clk = ~clk;

  jt93cxx #(.AW(6), .DW(16), .TWP(64)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .scs       (scs & ~sel),
    .sdo       (sdo16),
    .host_busy (hb16)
`ifdef JT93CXX_HOST_EN
    ,
    .host_addr (ha16),
    .host_din  (hd16),
    .host_we   (hw16),
    .host_dout (hq16)
`endif
  );

  jt93cxx #(.AW(6), .DW(8), .TWP(64)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .scs       (scs & sel),
    .sdo       (sdo8),
    .host_busy (hb8)
`ifdef JT93CXX_HOST_EN
    ,
    .host_addr (ha8),
    .host_din  (hd8),
    .host_we   (hw8),
    .host_dout (hq8)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_sdo();
    return sel ? sdo8 : sdo16;
  endfunction

  task automatic pick_dut(input logic s);
    sel = s;
    na  = s ? 7 : 6;
    nd  = s ? 8 : 16;
  endtask

  // ---------------- reference model ----------------
  task automatic set_we(input logic b);
    if (sel) we8 = b;
    else we16 = b;
  endtask

  task automatic m_write(input int a, input logic [15:0] d);
    if (sel && we8) ref8[a] = d[7:0];
    else if (!sel && we16) ref16[a] = d;
  endtask

  task automatic m_all(input logic [15:0] d);
    if (sel && we8) for (int i = 0; i < 128; i++) ref8[i] = d[7:0];
    else if (!sel && we16) for (int i = 0; i < 64; i++) ref16[i] = d;
  endtask

  function automatic logic [31:0] mexp(input int a, input int nw);
    logic [31:0] r = '0;
    int depth = sel ? 128 : 64;
    for (int w = 0; w < nw; w++) begin
      int x = (a + w) % depth;
      r = (r << nd) | (sel ? 32'(ref8[x]) : 32'(ref16[x]));
    end
    return r;
  endfunction

  // ---------------- serial driver ----------------
  task automatic sbit(input logic b);
    sdi  = b;
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  function automatic logic [31:0] cmd_word(input logic [1:0] op, input int a);
    return (32'd1 << (na + 2)) | (32'(op) << na) | 32'(a);
  endfunction

  task automatic cmd(input logic [1:0] op, input int a);
    scs = 1'b1;
    send_bits(cmd_word(op, a), na + 3);
  endtask

  task automatic deselect();
    scs = 1'b0;
    sdi = 1'b0;
    tick(4);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cur_sdo() !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    check("ready_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic ewen();
    scs = 1'b1;
    sbit(1'b0);  // leading zeros before the start bit
    sbit(1'b0);
    cmd(2'b00, 3 << (na - 2));
    deselect();
    set_we(1'b1);
  endtask

  task automatic ewds();
    cmd(2'b00, 0);
    deselect();
    set_we(1'b0);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    cmd(2'b01, a);
    send_bits(32'(d), nd);
    deselect();
    wait_ready();
    m_write(a, d);
  endtask

  task automatic erase(input int a);
    cmd(2'b11, a);
    deselect();
    wait_ready();
    m_write(a, 16'hFFFF);
  endtask

  task automatic rdchk(input string tag, input int a, input int nw);
    logic [31:0] got = '0;
    logic dm;
    cmd(2'b10, a);
    dm = cur_sdo();
    for (int k = 0; k < nw * nd; k++) begin
      sbit(1'($urandom));
      got = {got[30:0], cur_sdo()};
    end
    deselect();
    check({tag, "_dummy"}, 32'(dm), 32'd0);
    check(tag, got, mexp(a, nw));
  endtask

  // Issue the final decisive bit and count clk cycles of busy (x16 instance).
  task automatic last_bit_measure(input logic b, input logic use_hb, output int lo);
    int n = 0;
    lo = 0;
    sdi  = b;
    sclk = 1'b1;
    while (!(use_hb ? hb16 : !sdo16) && n < 20) begin
      tick(1);
      n++;
    end
    while ((use_hb ? hb16 : !sdo16) && lo < 1000) begin
      tick(1);
      lo++;
    end
    sclk = 1'b0;
    scs  = 1'b0;
    sdi  = 1'b0;
    tick(4);
  endtask

  initial begin
    int lo;
    int a;
    logic [15:0] d;
    logic [31:0] w;

    for (int i = 0; i < 64; i++) ref16[i] = '1;
    for (int i = 0; i < 128; i++) ref8[i] = '1;
    we16 = 1'b0;
    we8  = 1'b0;

    tick(4);
    check("rst_sdo", 32'(sdo16), 32'd1);
    check("rst_host_busy", 32'(hb16), 32'd0);
    rst_n = 1'b1;
    tick(2);

    pick_dut(1'b0);
    rdchk("fresh_rd5", 5, 1);

    wr(3, 16'h1234);  // refused: write not enabled
    rdchk("noewen_rd3", 3, 1);

    ewen();
    d = 16'h1234;
    cmd(2'b01, 3);
    send_bits(32'(d) >> 1, 15);
    last_bit_measure(d[0], 1'b0, lo);
    m_write(3, d);
    check("write_busy_len", 32'(lo), 32'd64);
    check("ready_after_write", 32'(sdo16), 32'd1);
    rdchk("rd3", 3, 1);

    wr(63, 16'hAAAA);
    wr(0, 16'h5555);
    rdchk("seq_wrap", 63, 2);

    d = 16'hBEEF;
    cmd(2'b00, 1 << (na - 2));
    send_bits(32'(d) >> 1, 15);
    last_bit_measure(d[0], 1'b1, lo);
    m_all(d);
    check("wral_busy_len", 32'(lo), 32'd128);
    rdchk("wral_rd0", 0, 1);
    rdchk("wral_rd63", 63, 1);

    scs = 1'b1;
    w = cmd_word(2'b00, 2 << (na - 2));
    send_bits(w >> 1, na + 2);
    last_bit_measure(w[0], 1'b1, lo);
    m_all(16'hFFFF);
    check("eral_busy_len", 32'(lo), 32'd128);
    for (int i = 0; i < 3; i++) rdchk("eral_rd", $urandom_range(0, 63), 1);

    wr(7, 16'h0F0F);
    cmd(2'b01, 7);
    send_bits(32'hA5, 8);
    deselect();
    wait_ready();
    rdchk("partial_rd7", 7, 1);

    d = 16'h600D;
    cmd(2'b01, 9);
    send_bits(32'(d), 16);
    deselect();
    m_write(9, d);
    tick(10);
    check("in_busy_sdo", 32'(sdo16), 32'd0);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_busy_sdo", 32'(sdo16), 32'd1);
    check("rst_mid_busy_hb", 32'(hb16), 32'd0);
    rst_n = 1'b1;
    we16 = 1'b0;
    we8  = 1'b0;
    tick(2);
    rdchk("retained9", 9, 1);
    wr(9, 16'h1234);  // refused again after reset
    rdchk("rst_wrdis9", 9, 1);

    ewen();
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 63);
      wr(a, 16'($urandom));
      rdchk("rand_rd", a, 1);
    end
    a = $urandom_range(0, 63);
    erase(a);
    rdchk("erase_rd", a, 1);
    a = $urandom_range(0, 63);
    wr(a, 16'($urandom));
    ewds();
    wr(a, 16'h1234);
    rdchk("ewds_rd", a, 1);

    pick_dut(1'b1);
    ewen();
    wr(100, 16'h005A);
    rdchk("dw8_rd100", 100, 1);
`ifdef JT93CXX_HOST_EN
    ha8 = 7'd100;
    tick(2);
    check("host_dout100", 32'(hq8), 32'h5A);
    ha8 = 7'd50;
    hd8 = 8'($urandom);
    hw8 = 1'b1;
    tick(1);
    hw8 = 1'b0;
    ref8[50] = hd8;
    rdchk("host_wr50", 50, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 127);
      wr(a, 16'($urandom));
      rdchk("dw8_rand", a, 1);
    end
    wr(127, 16'($urandom));
    wr(0, 16'($urandom));
    rdchk("dw8_wrap", 127, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
